// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg
//
// Purpose: shared CPU pipeline definitions used by the hazard controller.
//          Holds the pipeline depth, the hazard FSM state encoding, the packed
//          bundle of stall/flush controls and a helper that decides whether a
//          single decode source operand collides with an in-flight load.
//
// Ports:   none (package).
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    // F1, F2, D, E, M, W
    localparam int NUM_STAGES = 6;

    // Architectural register index width (x0..x31).
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } hz_state_t;

    // All pipeline-register controls in one bundle so each FSM branch can
    // assign a complete, self-consistent set in a single statement.
    typedef struct packed {
        logic stall_f1;
        logic stall_f2;
        logic stall_d;
        logic stall_e;
        logic flush_f2;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_NONE     = '0;

    // Mispredict: throw away everything fetched down the wrong path that has
    // already reached F2, D and E.
    localparam hz_ctl_t CTL_MISPRED  = '{stall_f1: 1'b0, stall_f2: 1'b0,
                                         stall_d:  1'b0, stall_e:  1'b0,
                                         flush_f2: 1'b1, flush_d:  1'b1,
                                         flush_e:  1'b1, flush_m:  1'b0};

    // Second redirect cycle: only the instruction sitting in F1 when the
    // mispredict resolved is still wrong-path, and it is now moving into F2.
    localparam hz_ctl_t CTL_REDIRECT = '{stall_f1: 1'b0, stall_f2: 1'b0,
                                         stall_d:  1'b0, stall_e:  1'b0,
                                         flush_f2: 1'b1, flush_d:  1'b0,
                                         flush_e:  1'b0, flush_m:  1'b0};

    // Mul/div busy: freeze everything up to and including E, and feed M a
    // bubble so the frozen E instruction is not retired twice.
    localparam hz_ctl_t CTL_MD_BUSY  = '{stall_f1: 1'b1, stall_f2: 1'b1,
                                         stall_d:  1'b1, stall_e:  1'b1,
                                         flush_f2: 1'b0, flush_d:  1'b0,
                                         flush_e:  1'b0, flush_m:  1'b1};

    // Load-use: hold the consumer in D and let a bubble advance into E.
    localparam hz_ctl_t CTL_LOAD_USE = '{stall_f1: 1'b1, stall_f2: 1'b1,
                                         stall_d:  1'b1, stall_e:  1'b0,
                                         flush_f2: 1'b0, flush_d:  1'b0,
                                         flush_e:  1'b1, flush_m:  1'b0};

    // Load data only becomes forwardable once the load reaches W, so a
    // consumer in D must wait while the producing load is in E or in M.
    // x0 is hard-wired to zero and never creates a dependency.
    function automatic logic src_load_hit(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_e,
        input logic             mem_read_e,
        input logic [REG_W-1:0] rd_m,
        input logic             mem_read_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = mem_read_e && (rs == rd_e);
        hit_m = mem_read_m && (rs == rd_m);
        return use_rs && (rs != '0) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//
// Purpose: free-running event counter that advances by one on every clock
//          edge where 'en' is high and sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset, clears the count
//   en     in   count this cycle
//   count  out  CNT_W-bit current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    // Next count: hold once every bit is set so a long run of events
    // reports "at least this many" rather than wrapping back to a small value.
    always_comb begin
        count_d = count_q;
        at_max  = &count_q;
        if (en && !at_max) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose: stall/flush controller for a six-stage in-order pipeline
//          (F1, F2, D, E, M, W). It resolves three hazard sources, highest
//          priority first:
//            1. branch/jump mispredict resolved in E (two-cycle redirect),
//            2. multi-cycle mul/div occupying E (stall until done),
//            3. load-use on a decode source (load data only forwardable from W).
//          It also keeps two saturating performance counters.
//
// Ports:
//   clk                in   single clock, rising edge
//   rst_n              in   synchronous active-low reset
//   Rs1D, Rs2D         in   decode-stage source registers
//   UseRs1D, UseRs2D   in   decode instruction really reads Rs1D / Rs2D
//   RdE, RdM           in   destination registers of the E / M instructions
//   MemReadE, MemReadM in   E / M instruction is a load
//   BranchMispredictE  in   control transfer resolved in E was mispredicted
//   MdStartE, MdDoneE  in   mul/div in E started / result ready
//   StallF1..StallE    out  hold the named pipeline register
//   FlushF2..FlushM    out  load a bubble into the named pipeline register
//   LoadStallCnt       out  cycles spent in a load-use stall (saturating)
//   FlushCnt           out  accepted mispredicts (saturating)
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             UseRs1D,
    input  logic             UseRs2D,

    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic             MemReadE,
    input  logic             MemReadM,

    input  logic             BranchMispredictE,
    input  logic             MdStartE,
    input  logic             MdDoneE,

    output logic             StallF1,
    output logic             StallF2,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushF2,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,

    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    hz_state_t state_q;
    hz_state_t state_d;

    hz_ctl_t   ctl;
    logic      load_use;
    logic      load_stall_evt;
    logic      flush_evt;

    // Raw load-use detection, independent of the FSM. Whether it actually
    // produces a stall is decided below, after the higher-priority hazards.
    always_comb begin
        load_use = src_load_hit(UseRs1D, Rs1D, RdE, MemReadE, RdM, MemReadM)
                 | src_load_hit(UseRs2D, Rs2D, RdE, MemReadE, RdM, MemReadM);
    end

    // Next state and all stall/flush outputs. Each hazard assigns a whole
    // control bundle, so a lower-priority hazard can never leak a stray bit
    // into a cycle owned by a higher-priority one, and no bundle stalls and
    // flushes the same register.
    //
    // While rst_n is low everything is forced quiet in the same cycle, which
    // is also what guarantees nothing from an abandoned MD_WAIT or REDIRECT
    // survives into the first cycle after release.
    always_comb begin
        state_d        = state_q;
        ctl            = CTL_NONE;
        load_stall_evt = 1'b0;
        flush_evt      = 1'b0;

        if (!rst_n) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (BranchMispredictE) begin
                        ctl       = CTL_MISPRED;
                        flush_evt = 1'b1;
                        state_d   = REDIRECT;
                    end else if (MdStartE && !MdDoneE) begin
                        ctl     = CTL_MD_BUSY;
                        state_d = MD_WAIT;
                    end else if (load_use) begin
                        ctl            = CTL_LOAD_USE;
                        load_stall_evt = 1'b1;
                    end
                end

                // The frozen mul/div keeps E occupied; the pipeline is released
                // in the very cycle the result is ready, with nothing asserted.
                MD_WAIT: begin
                    if (MdDoneE) begin
                        state_d = RUN;
                    end else begin
                        ctl = CTL_MD_BUSY;
                    end
                end

                // D and E were just flushed, so any load-use seen now refers to
                // wrong-path instructions and must not stall.
                REDIRECT: begin
                    ctl     = CTL_REDIRECT;
                    state_d = RUN;
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign StallF1 = ctl.stall_f1;
    assign StallF2 = ctl.stall_f2;
    assign StallD  = ctl.stall_d;
    assign StallE  = ctl.stall_e;
    assign FlushF2 = ctl.flush_f2;
    assign FlushD  = ctl.flush_d;
    assign FlushE  = ctl.flush_e;
    assign FlushM  = ctl.flush_m;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_load_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_stall_evt),
        .count (LoadStallCnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_evt),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Drives two hazard_ctrl instances from the same inputs: one with the default
// 16-bit counters and one with 4-bit counters so saturation is reachable.
// Expected outputs come from a small rule-level model of the hazard
// priorities kept in this file.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdE, RdM;
    logic       UseRs1D, UseRs2D, MemReadE, MemReadM;
    logic       BranchMispredictE, MdStartE, MdDoneE;

    // {StallF1, StallF2, StallD, StallE, FlushF2, FlushD, FlushE, FlushM}
    logic [7:0]  ctl_a, ctl_b;
    logic [15:0] ls_cnt_a, fl_cnt_a;
    logic [3:0]  ls_cnt_b, fl_cnt_b;

    hazard_ctrl #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RdE(RdE), .RdM(RdM), .MemReadE(MemReadE), .MemReadM(MemReadM),
        .BranchMispredictE(BranchMispredictE), .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF1(ctl_a[7]), .StallF2(ctl_a[6]), .StallD(ctl_a[5]), .StallE(ctl_a[4]),
        .FlushF2(ctl_a[3]), .FlushD(ctl_a[2]), .FlushE(ctl_a[1]), .FlushM(ctl_a[0]),
        .LoadStallCnt(ls_cnt_a), .FlushCnt(fl_cnt_a)
    );

    hazard_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RdE(RdE), .RdM(RdM), .MemReadE(MemReadE), .MemReadM(MemReadM),
        .BranchMispredictE(BranchMispredictE), .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF1(ctl_b[7]), .StallF2(ctl_b[6]), .StallD(ctl_b[5]), .StallE(ctl_b[4]),
        .FlushF2(ctl_b[3]), .FlushD(ctl_b[2]), .FlushE(ctl_b[1]), .FlushM(ctl_b[0]),
        .LoadStallCnt(ls_cnt_b), .FlushCnt(fl_cnt_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: is a redirect flush owed this cycle, is a mul/div occupying E,
    // and how many events of each kind happened since reset.
    bit m_redirect_owed;
    bit m_md_busy;
    int m_ls_events;
    int m_fl_events;

    // Updates decided during the check, committed at the clock edge.
    bit n_redirect_owed;
    bit n_md_busy;
    bit n_ls_inc;
    bit n_fl_inc;

    localparam logic [7:0] EXP_NONE     = 8'b0000_0000;
    localparam logic [7:0] EXP_MISPRED  = 8'b0000_1110;
    localparam logic [7:0] EXP_REDIRECT = 8'b0000_1000;
    localparam logic [7:0] EXP_MD_BUSY  = 8'b1111_0001;
    localparam logic [7:0] EXP_LOADUSE  = 8'b1110_0010;

    function automatic bit srcHit(input logic use_rs, input logic [4:0] rs);
        return use_rs && (rs != 5'd0) &&
               ((MemReadE && rs == RdE) || (MemReadM && rs == RdM));
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic setIdle();
        Rs1D = 5'd0; Rs2D = 5'd0; UseRs1D = 1'b0; UseRs2D = 1'b0;
        RdE = 5'd0; RdM = 5'd0; MemReadE = 1'b0; MemReadM = 1'b0;
        BranchMispredictE = 1'b0; MdStartE = 1'b0; MdDoneE = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_ctl;
        bit         lu;
        exp_ctl         = EXP_NONE;
        n_redirect_owed = 1'b0;
        n_md_busy       = m_md_busy;
        n_ls_inc        = 1'b0;
        n_fl_inc        = 1'b0;
        lu = srcHit(UseRs1D, Rs1D) || srcHit(UseRs2D, Rs2D);

        if (!rst_n) begin
            n_md_busy = 1'b0;
        end else if (m_redirect_owed) begin
            exp_ctl = EXP_REDIRECT;
        end else if (m_md_busy) begin
            if (!MdDoneE) exp_ctl = EXP_MD_BUSY;
            else          n_md_busy = 1'b0;
        end else if (BranchMispredictE) begin
            exp_ctl         = EXP_MISPRED;
            n_redirect_owed = 1'b1;
            n_fl_inc        = 1'b1;
        end else if (MdStartE && !MdDoneE) begin
            exp_ctl   = EXP_MD_BUSY;
            n_md_busy = 1'b1;
        end else if (lu) begin
            exp_ctl  = EXP_LOADUSE;
            n_ls_inc = 1'b1;
        end

        n_assert++;
        assert (ctl_a === exp_ctl) else begin
            n_fail++;
            $error("[TB] FAIL %s ctl16: got %b expected %b", tag, ctl_a, exp_ctl);
        end
        n_assert++;
        assert (ctl_b === exp_ctl) else begin
            n_fail++;
            $error("[TB] FAIL %s ctl4: got %b expected %b", tag, ctl_b, exp_ctl);
        end
        n_assert++;
        assert (ls_cnt_a === sat16(m_ls_events)) else begin
            n_fail++;
            $error("[TB] FAIL %s LoadStallCnt16: got %0d expected %0d", tag, ls_cnt_a, sat16(m_ls_events));
        end
        n_assert++;
        assert (fl_cnt_a === sat16(m_fl_events)) else begin
            n_fail++;
            $error("[TB] FAIL %s FlushCnt16: got %0d expected %0d", tag, fl_cnt_a, sat16(m_fl_events));
        end
        n_assert++;
        assert (ls_cnt_b === sat4(m_ls_events)) else begin
            n_fail++;
            $error("[TB] FAIL %s LoadStallCnt4: got %0d expected %0d", tag, ls_cnt_b, sat4(m_ls_events));
        end
        n_assert++;
        assert (fl_cnt_b === sat4(m_fl_events)) else begin
            n_fail++;
            $error("[TB] FAIL %s FlushCnt4: got %0d expected %0d", tag, fl_cnt_b, sat4(m_fl_events));
        end
    endtask

    // Inputs are set by the caller just after the previous edge; the check
    // happens mid-cycle and the model advances with the DUT at the next edge.
    task automatic applyStimulus(input string tag);
        @(negedge clk);
        #1;
        checkOutput(tag);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_redirect_owed = 1'b0;
            m_md_busy       = 1'b0;
            m_ls_events     = 0;
            m_fl_events     = 0;
        end else begin
            m_redirect_owed = n_redirect_owed;
            m_md_busy       = n_md_busy;
            m_ls_events     = m_ls_events + int'(n_ls_inc);
            m_fl_events     = m_fl_events + int'(n_fl_inc);
        end
    endtask

    initial begin
        int r;
        setIdle();
        rst_n           = 1'b0;
        m_redirect_owed = 1'b0;
        m_md_busy       = 1'b0;
        m_ls_events     = 0;
        m_fl_events     = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset_hold");
        rst_n = 1'b1;
        applyStimulus("idle");

        // lw x5 in E, add x6,x5,x1 in D: two stall cycles as the load walks E->M
        Rs1D = 5'd5; UseRs1D = 1'b1; Rs2D = 5'd1; UseRs2D = 1'b1;
        RdE = 5'd5; MemReadE = 1'b1;
        applyStimulus("lu_e_c1");
        RdE = 5'd0; MemReadE = 1'b0; RdM = 5'd5; MemReadM = 1'b1;
        applyStimulus("lu_e_c2");
        RdM = 5'd0; MemReadM = 1'b0;
        applyStimulus("lu_e_done");
        n_assert++;
        assert (ls_cnt_a === 16'd2) else begin
            n_fail++;
            $error("[TB] FAIL lu_e_count: got %0d expected 2", ls_cnt_a);
        end

        // Load only in M, plus x0 and unused-source exclusions
        setIdle();
        RdM = 5'd5; MemReadM = 1'b1; Rs1D = 5'd5; UseRs1D = 1'b1;
        applyStimulus("lu_m");
        Rs1D = 5'd0;
        applyStimulus("lu_m_x0");
        RdM = 5'd0;
        applyStimulus("lu_m_x0_rd0");
        RdM = 5'd5; Rs1D = 5'd5; UseRs1D = 1'b0;
        applyStimulus("lu_m_nouse");
        Rs2D = 5'd5; UseRs2D = 1'b1;
        applyStimulus("lu_m_rs2");
        MemReadM = 1'b0;
        applyStimulus("no_load");

        // Mispredict, with a load-use present during the redirect cycle
        setIdle();
        BranchMispredictE = 1'b1;
        applyStimulus("bmp");
        BranchMispredictE = 1'b0;
        RdE = 5'd5; MemReadE = 1'b1; Rs1D = 5'd5; UseRs1D = 1'b1;
        applyStimulus("redirect");
        setIdle();
        applyStimulus("after_redirect");

        // Mul/div with a load-use that must stay hidden behind it
        RdE = 5'd7; MemReadE = 1'b1; Rs1D = 5'd7; UseRs1D = 1'b1;
        MdStartE = 1'b1;
        applyStimulus("md_start");
        setIdle();
        repeat (3) applyStimulus("md_wait");
        MdDoneE = 1'b1;
        applyStimulus("md_done");
        MdDoneE = 1'b0;
        applyStimulus("md_after");
        MdStartE = 1'b1; MdDoneE = 1'b1;
        applyStimulus("md_single");
        setIdle();
        applyStimulus("md_single_after");

        // Reset in the middle of MD_WAIT and of REDIRECT
        MdStartE = 1'b1;
        applyStimulus("md2_start");
        MdStartE = 1'b0;
        applyStimulus("md2_wait");
        rst_n = 1'b0;
        applyStimulus("rst_mid_md");
        rst_n = 1'b1;
        applyStimulus("post_rst_md");
        BranchMispredictE = 1'b1;
        applyStimulus("bmp2");
        BranchMispredictE = 1'b0;
        rst_n = 1'b0;
        applyStimulus("rst_mid_redirect");
        rst_n = 1'b1;
        applyStimulus("post_rst_redirect");

        // Twenty consecutive load-use cycles: 4-bit counter pins at 15
        RdE = 5'd5; MemReadE = 1'b1; Rs1D = 5'd5; UseRs1D = 1'b1;
        repeat (20) applyStimulus("sat_run");
        setIdle();
        applyStimulus("sat_hold");
        n_assert++;
        assert (ls_cnt_b === 4'd15) else begin
            n_fail++;
            $error("[TB] FAIL sat_cnt4: got %0d expected 15", ls_cnt_b);
        end

        // Randomised traffic with a narrow register range so collisions are common
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            Rs1D     = 5'($urandom_range(0, 3));
            Rs2D     = 5'($urandom_range(0, 3));
            RdE      = 5'($urandom_range(0, 3));
            RdM      = 5'($urandom_range(0, 3));
            UseRs1D  = 1'($urandom_range(0, 1));
            UseRs2D  = 1'($urandom_range(0, 1));
            MemReadE = 1'($urandom_range(0, 1));
            MemReadM = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            BranchMispredictE = (r == 0);
            MdStartE = (r == 1) || (r == 2);
            MdDoneE  = ($urandom_range(0, 2) == 0);
            applyStimulus("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
